// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and the
// 2-of-3 majority helper used for bit decisions.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous serial input, plus a registered
// previous sample so consumers get a clean falling-edge strobe.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall_edge
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
      prev <= rx_s;
    end
  end

  assign fall_edge = prev & ~rx_s;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: data width, parity and stop bits set by
// parameters; 3-sample majority per bit, parity/framing/break reporting.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PAR_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned H  = CLKS_PER_BIT / 2;

  rx_state_e            state;
  logic [CW-1:0]        clk_cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [2:0]           smp;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 ferr;
  logic                 all_zero;
  logic                 pend;
  logic                 rx_s;
  logic                 fall_edge;
  logic                 bit_last;
  logic                 bit_val;
  logic                 par_err;

  uart_rx_sync u_sync (
    .clk      (i_Clock),
    .rst_n    (i_Rst_L),
    .rx       (i_RX_Serial),
    .rx_s     (rx_s),
    .fall_edge(fall_edge)
  );

  always_comb begin
    bit_last = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    bit_val  = maj3(smp[0], smp[1], smp[2]);
    par_err  = 1'b0;
    if (PARITY != PAR_NONE) begin
      par_err = ((^shreg) ^ par_bit) != (PARITY == PAR_ODD);
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state        <= IDLE;
      clk_cnt      <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      smp          <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      ferr         <= 1'b0;
      all_zero     <= 1'b0;
      pend         <= 1'b0;
      o_RX_DV      <= 1'b0;
      o_RX_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
      o_Busy       <= 1'b0;
    end else begin
      o_RX_DV <= 1'b0;
      if (state != IDLE && state != DONE) begin
        if (clk_cnt == CW'(H - 1)) smp[0] <= rx_s;
        if (clk_cnt == CW'(H))     smp[1] <= rx_s;
        if (clk_cnt == CW'(H + 1)) smp[2] <= rx_s;
        clk_cnt <= bit_last ? '0 : clk_cnt + CW'(1);
      end
      case (state)
        IDLE: begin
          if (fall_edge) begin
            state   <= START;
            clk_cnt <= '0;
            o_Busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_last) begin
            if (bit_val) begin
              state  <= IDLE;
              o_Busy <= 1'b0;
            end else begin
              state    <= DATA;
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              ferr     <= 1'b0;
              all_zero <= 1'b1;
            end
          end
        end
        DATA: begin
          if (bit_last) begin
            shreg    <= {bit_val, shreg[DATA_BITS-1:1]};
            all_zero <= all_zero & ~bit_val;
            if (bit_idx == 4'(DATA_BITS - 1)) begin
              state <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        // Qualified: the PARITY parameter shadows the state name.
        uart_pkg::PARITY: begin
          if (bit_last) begin
            par_bit  <= bit_val;
            all_zero <= all_zero & ~bit_val;
            state    <= STOP;
          end
        end
        STOP: begin
          if (bit_last) begin
            ferr     <= ferr | ~bit_val;
            all_zero <= all_zero & ~bit_val;
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              state <= DONE;
              // A start edge landing right at the stop-bit end is kept for DONE.
              pend  <= fall_edge;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        DONE: begin
          o_RX_DV      <= 1'b1;
          o_RX_Byte    <= shreg;
          o_Parity_Err <= par_err;
          o_Frame_Err  <= ferr;
          o_Break      <= all_zero;
          pend         <= 1'b0;
          if (pend || fall_edge) begin
            state   <= START;
            clk_cnt <= pend ? CW'(1) : '0;
          end else begin
            state  <= IDLE;
            o_Busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations on one serial line, directed
// cases plus randomized frames checked against a frame-level model.
module tb_uart_rx_cfg;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;
  localparam int GAP = 14;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       dv_a, pe_a, fe_a, brk_a, busy_a;
  logic       dv_b, pe_b, fe_b, brk_b, busy_b;
  logic       dv_c, pe_c, fe_c, brk_c, busy_c;
  logic [7:0] byte_a;
  logic [6:0] byte_b;
  logic [7:0] byte_c;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         cyc;
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } ev_t;

  ev_t q_a[$];
  ev_t q_b[$];
  ev_t q_c[$];

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx), .o_RX_DV(dv_a), .o_RX_Byte(byte_a),
    .o_Parity_Err(pe_a), .o_Frame_Err(fe_a), .o_Break(brk_a), .o_Busy(busy_a)
  );
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_b (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx), .o_RX_DV(dv_b), .o_RX_Byte(byte_b),
    .o_Parity_Err(pe_b), .o_Frame_Err(fe_b), .o_Break(brk_b), .o_Busy(busy_b)
  );
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_c (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx), .o_RX_DV(dv_c), .o_RX_Byte(byte_c),
    .o_Parity_Err(pe_c), .o_Frame_Err(fe_c), .o_Break(brk_c), .o_Busy(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (dv_a) begin
      e.cyc = cyc; e.data = 9'(byte_a); e.pe = pe_a; e.fe = fe_a; e.brk = brk_a;
      q_a.push_back(e);
    end
    if (dv_b) begin
      e.cyc = cyc; e.data = 9'(byte_b); e.pe = pe_b; e.fe = fe_b; e.brk = brk_b;
      q_b.push_back(e);
    end
    if (dv_c) begin
      e.cyc = cyc; e.data = 9'(byte_c); e.pe = pe_c; e.fe = fe_c; e.brk = brk_c;
      q_c.push_back(e);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int nbits(input int db, input int par, input int sb);
    return 1 + db + ((par != 0) ? 1 : 0) + sb;
  endfunction

  function automatic logic [15:0] build(input int db, input int par, input int sb,
                                        input logic [8:0] data, input logic p,
                                        input logic [1:0] stops);
    logic [15:0] f;
    int          n;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < db; i++) f[1 + i] = data[i];
    n = 1 + db;
    if (par != 0) begin
      f[n] = p;
      n++;
    end
    for (int i = 0; i < sb; i++) f[n + i] = stops[i];
    return f;
  endfunction

  // Called at a negedge; each loop step sets the line for the following posedge.
  task automatic send_frame(input logic [15:0] bits, input int nb, input int glo,
                            input int ghi, input int gap, input int abort_at,
                            output int edge0);
    logic b;
    int   idx;
    edge0 = cyc + 1;
    for (int c = 0; c < nb * CPB; c++) begin
      idx = c / CPB;
      b   = bits[idx];
      if (idx >= glo && idx <= ghi && (c % CPB) == H + 1) b = ~b;
      if (c == abort_at) begin
        rst_n = 1'b0;
        rx    = 1'b1;
        return;
      end
      rx = b;
      @(negedge clk);
    end
    rx = 1'b1;
    repeat (gap * CPB) @(negedge clk);
  endtask

  task automatic expect_ev(input string tag, input int which, input int k, input int nexp,
                           input int db, input int par, input int sb,
                           input logic [8:0] data, input logic p, input logic [1:0] stops,
                           input int edge0);
    ev_t        q[$];
    logic [8:0] d;
    logic       epe, efe, ebrk;
    int         n;
    case (which)
      0:       q = q_a;
      1:       q = q_b;
      default: q = q_c;
    endcase
    d    = data & ((9'h1 << db) - 9'h1);
    epe  = (par != 0) && (((^d) ^ p) != (par == 1));
    efe  = !stops[0] || (sb == 2 && !stops[1]);
    ebrk = (d == 9'h0) && (par == 0 || !p) && !stops[0] && (sb == 1 || !stops[1]);
    n    = nbits(db, par, sb);
    check({tag, ".ndv"}, 32'(q.size()), 32'(nexp));
    if (q.size() > k) begin
      check({tag, ".byte"}, 32'(q[k].data), 32'(d));
      check({tag, ".perr"}, 32'(q[k].pe), 32'(epe));
      check({tag, ".ferr"}, 32'(q[k].fe), 32'(efe));
      check({tag, ".brk"},  32'(q[k].brk), 32'(ebrk));
      check({tag, ".lat"},  32'(q[k].cyc), 32'(edge0 + 3 + n * CPB));
    end
  endtask

  task automatic clear_q();
    q_a.delete();
    q_b.delete();
    q_c.delete();
  endtask

  initial begin
    int          e0, e1, k, db, par, sb;
    logic [8:0]  data;
    logic        p;
    logic [1:0]  stops;
    int          glo, ghi;

    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst.dv",   32'(dv_a),   0);
    check("rst.byte", 32'(byte_a), 0);
    check("rst.flags", 32'({pe_a, fe_a, brk_a}), 0);
    check("rst.busy", 32'({busy_a, busy_b, busy_c}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 nominal frame
    clear_q();
    send_frame(build(8, 0, 1, 9'hA5, 1'b0, 2'b11), nbits(8, 0, 1), 99, -1, GAP, -1, e0);
    expect_ev("t1", 0, 0, 1, 8, 0, 1, 9'hA5, 1'b0, 2'b11, e0);

    // Short low glitch: false start only
    clear_q();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    check("glitch.busy_hi", 32'(busy_a), 1);
    repeat (CPB) @(negedge clk);
    check("glitch.busy_lo", 32'(busy_a), 0);
    repeat (GAP * CPB) @(negedge clk);
    check("glitch.ndv", 32'(q_a.size()), 0);
    check("glitch.byte", 32'(byte_a), 32'h A5);
    check("glitch.flags", 32'({pe_a, fe_a, brk_a}), 0);

    // 7E1: good then bad parity
    clear_q();
    send_frame(build(7, 2, 1, 9'h41, 1'b0, 2'b11), nbits(7, 2, 1), 99, -1, GAP, -1, e0);
    expect_ev("t2.ok", 1, 0, 1, 7, 2, 1, 9'h41, 1'b0, 2'b11, e0);
    clear_q();
    send_frame(build(7, 2, 1, 9'h41, 1'b1, 2'b11), nbits(7, 2, 1), 99, -1, GAP, -1, e0);
    expect_ev("t2.bad", 1, 0, 1, 7, 2, 1, 9'h41, 1'b1, 2'b11, e0);

    // 8N2: second stop bit low, then a long break
    clear_q();
    send_frame(build(8, 0, 2, 9'h3C, 1'b0, 2'b01), nbits(8, 0, 2), 99, -1, GAP, -1, e0);
    expect_ev("t3.stop2", 2, 0, 1, 8, 0, 2, 9'h3C, 1'b0, 2'b01, e0);
    clear_q();
    send_frame(16'h0000, 12, 99, -1, GAP, -1, e0);
    expect_ev("t3.brk", 2, 0, 1, 8, 0, 2, 9'h00, 1'b0, 2'b00, e0);
    clear_q();
    send_frame(build(8, 0, 2, 9'h81, 1'b0, 2'b11), nbits(8, 0, 2), 99, -1, GAP, -1, e0);
    expect_ev("t3.after", 2, 0, 1, 8, 0, 2, 9'h81, 1'b0, 2'b11, e0);

    // Single-clock inversion at the middle sample of each data bit
    clear_q();
    send_frame(build(8, 0, 1, 9'h5A, 1'b0, 2'b11), nbits(8, 0, 1), 1, 8, GAP, -1, e0);
    expect_ev("t5", 0, 0, 1, 8, 0, 1, 9'h5A, 1'b0, 2'b11, e0);

    // Back-to-back frames, no idle between them
    clear_q();
    send_frame(build(8, 0, 1, 9'h3C, 1'b0, 2'b11), nbits(8, 0, 1), 99, -1, 0, -1, e0);
    send_frame(build(8, 0, 1, 9'hC3, 1'b0, 2'b11), nbits(8, 0, 1), 99, -1, GAP, -1, e1);
    expect_ev("b2b.0", 0, 0, 2, 8, 0, 1, 9'h3C, 1'b0, 2'b11, e0);
    expect_ev("b2b.1", 0, 1, 2, 8, 0, 1, 9'hC3, 1'b0, 2'b11, e1);

    // Reset during data bit 3
    clear_q();
    send_frame(build(8, 0, 1, 9'h96, 1'b0, 2'b11), nbits(8, 0, 1), 99, -1, 0,
               4 * CPB + H, e0);
    #1;
    check("rst_mid.dv",   32'(dv_a),   0);
    check("rst_mid.byte", 32'(byte_a), 0);
    check("rst_mid.busy", 32'(busy_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (GAP * CPB) @(negedge clk);
    check("rst_mid.ndv", 32'(q_a.size()), 0);
    clear_q();
    send_frame(build(8, 0, 1, 9'hFF, 1'b0, 2'b11), nbits(8, 0, 1), 99, -1, GAP, -1, e0);
    expect_ev("t6", 0, 0, 1, 8, 0, 1, 9'hFF, 1'b0, 2'b11, e0);

    // Randomized frames across all three configurations
    for (int it = 0; it < 24; it++) begin
      k     = $urandom_range(0, 2);
      db    = (k == 1) ? 7 : 8;
      par   = (k == 1) ? 2 : 0;
      sb    = (k == 2) ? 2 : 1;
      data  = 9'($urandom) & ((9'h1 << db) - 9'h1);
      p     = (^data) ^ (par == 1);
      if ($urandom_range(0, 3) == 0) p = ~p;
      stops = 2'b11;
      if ($urandom_range(0, 4) == 0) stops[0] = 1'b0;
      if ($urandom_range(0, 4) == 0) stops[1] = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        data  = 9'h0;
        p     = 1'b0;
        stops = 2'b00;
      end
      glo = 99;
      ghi = -1;
      if ($urandom_range(0, 1) == 1) begin
        glo = 1;
        ghi = db;
      end
      clear_q();
      send_frame(build(db, par, sb, data, p, stops), nbits(db, par, sb), glo, ghi, GAP, -1, e0);
      expect_ev($sformatf("rnd%0d", it), k, 0, 1, db, par, sb, data, p, stops, e0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
